// File: rtl/data_mem_responder_if.sv
// Request/response channel between the processor memory stage and the data memory.
// The requester drives the master side and the memory drives the slave side.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory serving one load/store at a time after WAIT_STATES cycles.
// Each request gets exactly one response; illegal addresses return an error and never write.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 n_reset,
    data_mem_responder_if.slave  bus,
    output logic                 busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem [2**ADDR_W];

    logic              commit;
    logic              cmt_we;
    logic [31:0]       cmt_addr;
    logic [31:0]       cmt_wdata;
    logic              cmt_legal;
    logic [ADDR_W-1:0] cmt_idx;

    // With zero wait states the commit happens on the accepting edge, so it uses the live request.
    assign cmt_we    = (state_q == ST_IDLE) ? bus.req_we    : we_q;
    assign cmt_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
    assign cmt_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
    assign cmt_legal = (cmt_addr[1:0] == 2'b00) && (cmt_addr[31:ADDR_W+2] == '0);
    assign cmt_idx   = cmt_addr[ADDR_W+1:2];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        commit        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            rdata_d = (cmt_legal && !cmt_we) ? mem[cmt_idx] : 32'd0;
            err_d   = !cmt_legal;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the storage array has no reset; contents stay undefined until written.
    always_ff @(posedge clk) begin
        if (n_reset && commit && cmt_we && cmt_legal) mem[cmt_idx] <= cmt_wdata;
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (0, 1 and 3 wait states) share one
// set of stimulus signals, routed to the instance chosen by sel.
module tb_data_mem_responder;
    logic        clk;
    logic        n_reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    int unsigned sel;

    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        busy0, busy1, busy2;

    int n_vec = 0;
    int n_bad = 0;

    data_mem_responder_if if0 ();
    data_mem_responder_if if1 ();
    data_mem_responder_if if2 ();

    assign if0.req_valid = req_valid && (sel == 0);
    assign if1.req_valid = req_valid && (sel == 1);
    assign if2.req_valid = req_valid && (sel == 2);
    assign if0.req_we = req_we;  assign if0.req_addr = req_addr;  assign if0.req_wdata = req_wdata;
    assign if1.req_we = req_we;  assign if1.req_addr = req_addr;  assign if1.req_wdata = req_wdata;
    assign if2.req_we = req_we;  assign if2.req_addr = req_addr;  assign if2.req_wdata = req_wdata;
    assign if0.rsp_ready = rsp_ready;
    assign if1.rsp_ready = rsp_ready;
    assign if2.rsp_ready = rsp_ready;

    data_mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_ws0 (.clk(clk), .n_reset(n_reset), .bus(if0.slave), .busy(busy0));
    data_mem_responder #(.ADDR_W(8), .WAIT_STATES(1)) u_ws1 (.clk(clk), .n_reset(n_reset), .bus(if1.slave), .busy(busy1));
    data_mem_responder #(.ADDR_W(8), .WAIT_STATES(3)) u_ws3 (.clk(clk), .n_reset(n_reset), .bus(if2.slave), .busy(busy2));

    always_comb begin
        req_ready = if1.req_ready;
        rsp_valid = if1.rsp_valid;
        rsp_rdata = if1.rsp_rdata;
        rsp_err   = if1.rsp_err;
        busy      = busy1;
        case (sel)
            0: begin req_ready = if0.req_ready; rsp_valid = if0.rsp_valid;
                     rsp_rdata = if0.rsp_rdata; rsp_err = if0.rsp_err; busy = busy0; end
            2: begin req_ready = if2.req_ready; rsp_valid = if2.rsp_valid;
                     rsp_rdata = if2.rsp_rdata; rsp_err = if2.rsp_err; busy = busy2; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int unsigned sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic int ws_of(input int unsigned s);
        case (s)
            0:       return 0;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    // Issue one request from a negedge in IDLE; return the response and the number of rising
    // edges from acceptance (inclusive) until rsp_valid is seen. Ends at a negedge in IDLE.
    task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int edges);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_AAAA;
        edges     = 1;
        while (!rsp_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_data [4];

        vt[0]  = '{1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vt[1]  = '{1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{1, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0, 1'b0};
        vt[3]  = '{1, 1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1};
        vt[4]  = '{1, 1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0, 1'b1};
        vt[5]  = '{1, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vt[6]  = '{1, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0, 1'b0};
        vt[7]  = '{1, 1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0};
        vt[8]  = '{1, 1'b1, 32'h8000_0000, 32'h7777_7777, 32'h0, 1'b1};
        vt[9]  = '{1, 1'b0, 32'h0000_0002, 32'h0,         32'h0, 1'b1};
        vt[10] = '{1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[11] = '{0, 1'b1, 32'h0000_0040, 32'h1000_0001, 32'h0, 1'b0};
        vt[12] = '{0, 1'b1, 32'h0000_0044, 32'h1000_0002, 32'h0, 1'b0};
        vt[13] = '{0, 1'b1, 32'h0000_0048, 32'h1000_0003, 32'h0, 1'b0};
        vt[14] = '{0, 1'b1, 32'h0000_004C, 32'h1000_0004, 32'h0, 1'b0};
        vt[15] = '{2, 1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0, 1'b0};
        vt[16] = '{2, 1'b0, 32'h0000_0020, 32'h0,         32'h1111_2222, 1'b0};

        b2b_addr = '{32'h48, 32'h40, 32'h4C, 32'h44};
        b2b_data = '{32'h1000_0003, 32'h1000_0001, 32'h1000_0004, 32'h1000_0002};

        sel = 1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        // Reset then idle, checked on every instance.
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check($sformatf("reset_req_ready[%0d]", s), 32'(req_ready), 32'd1);
            check($sformatf("reset_rsp_valid[%0d]", s), 32'(rsp_valid), 32'd0);
            check($sformatf("reset_busy[%0d]", s),      32'(busy),      32'd0);
            check($sformatf("reset_rsp_rdata[%0d]", s), rsp_rdata,      32'd0);
            check($sformatf("reset_rsp_err[%0d]", s),   32'(rsp_err),   32'd0);
        end
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            sel = vt[i].sel;
            transact(vt[i].we, vt[i].addr, vt[i].wdata, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(1 + ws_of(vt[i].sel)));
        end

        // Backpressure on the one-wait-state instance.
        sel = 1;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        begin
            int t = 0;
            while (!rsp_valid && t < 40) begin @(negedge clk); t++; end
            check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_valid_c%0d", c),     32'(rsp_valid), 32'd1);
            check($sformatf("bp_rdata_c%0d", c),     rsp_rdata,      32'hDEAD_BEEF);
            check($sformatf("bp_err_c%0d", c),       32'(rsp_err),   32'd0);
            check($sformatf("bp_req_ready_c%0d", c), 32'(req_ready), 32'd0);
            check($sformatf("bp_busy_c%0d", c),      32'(busy),      32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        check("bp_release_busy",  32'(busy),      32'd0);

        // Zero wait states, req_valid held high across four loads.
        sel = 0;
        begin
            int issued = 0, got = 0, cyc = 0, last = 0;
            req_we = 1'b0;
            while (got < 4 && cyc < 30) begin
                if (rsp_valid) begin
                    check($sformatf("b2b_rdata%0d", got), rsp_rdata, b2b_data[got]);
                    check($sformatf("b2b_err%0d", got), 32'(rsp_err), 32'd0);
                    if (got > 0) check($sformatf("b2b_spacing%0d", got), 32'(cyc - last), 32'd2);
                    last = cyc;
                    got++;
                end
                if (req_ready && issued < 4) begin
                    req_valid = 1'b1;
                    req_addr  = b2b_addr[issued];
                    issued++;
                end else if (!req_ready && issued == 4) begin
                    req_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            req_valid = 1'b0;
            check("b2b_all_responses", 32'(got), 32'd4);
            @(negedge clk);
        end

        // Reset during WAIT on the three-wait-state instance: store must not land.
        sel = 2;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h3333_4444;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstw_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #1 n_reset = 1'b0;
        @(negedge clk);
        check("rstw_valid_in_reset", 32'(rsp_valid), 32'd0);
        check("rstw_busy_in_reset",  32'(busy),      32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        begin
            int seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            check("rstw_no_response", 32'(seen), 32'd0);
        end
        check("rstw_req_ready", 32'(req_ready), 32'd1);
        transact(1'b0, 32'h20, 32'h0, rd, er, lat);
        check("rstw_load_rdata", rd, 32'h1111_2222);
        check("rstw_load_err",   32'(er), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
